mux_3x1: RTL and testbench
==========================

# mux_3x1

Parameterised 3-to-1 data selector with a combinational output and a registered copy of the selected data. Used wherever one of three equal-width sources must be steered onto a single path. The combinational path serves same-cycle consumers, and the registered path serves consumers that need a clean flop boundary. The illegal select code is flagged rather than silently aliased.

## Interface
- `WIDTH`, default 1: data width of `d0`, `d1`, `d2`, `y` and `y_q`; legal range 1..64.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `d0` in WIDTH: source 0, selected when `sel`=2'b00.
- `d1` in WIDTH: source 1, selected when `sel`=2'b01.
- `d2` in WIDTH: source 2, selected when `sel`=2'b10.
- `sel` in 2: select code; 2'b11 is illegal.
- `y` out WIDTH: combinational selected data.
- `y_q` out WIDTH: `y` registered on `clk`.
- `sel_err` out 1: sticky illegal-select flag; present only when `MUX_3X1_SEL_ERR_EN` is defined.

## Operation
- `y` is purely combinational from `d0`, `d1`, `d2` and `sel`. It has no dependency on `clk` or `rst_n`.
  - `sel`=00 → `y`=`d0`.
  - `sel`=01 → `y`=`d1`.
  - `sel`=10 → `y`=`d2`.
  - `sel`=11 → `y`=all zeros, never X and never an alias of any input.
- Any change on a data input or on `sel` propagates to `y` without a clock edge.
- `y_q` captures the current `y` on every rising `clk` edge. There is no enable; it always loads.
- `sel_err` (when compiled in):
  - Set on a rising edge where `sel`=11.
  - Stays 1 until `rst_n` is asserted; there is no other clear path.
- X or Z on `sel` is not required to produce a defined `y`. Benches keep `sel` driven.

## Timing
- Reset value of every output:
  - `y_q`=0 and `sel_err`=0, forced immediately on `rst_n` falling, independent of `clk`.
  - `y` follows its inputs during reset.
- Reset release is synchronous to use: the first rising edge with `rst_n`=1 loads `y_q`.
- Latency:
  - `y`: 0 cycles (combinational).
  - `y_q`: 1 cycle, i.e. `y_q` at edge N+1 equals `y` sampled at edge N.
  - `sel_err`: visible 1 cycle after the edge that samples `sel`=11.
- Reset asserted mid-operation clears `y_q` and `sel_err` at once. The combinational path is unaffected.
- Simultaneous `sel` change and data change: `y` reflects the new `sel` applied to the new data after settling.
- Setup/hold constraints apply to `d*` and `sel` only relative to `clk` for the `y_q` and `sel_err` paths.

## Configuration
- `MUX_3X1_SEL_ERR_EN` defined:
  - The `sel_err` port and its flop exist.
  - Behaviour is as described in Operation.
- `MUX_3X1_SEL_ERR_EN` undefined:
  - The `sel_err` port and its flop are absent.
  - `sel`=11 still drives `y`=0.
  - All other behaviour is identical.

## Test plan
- `WIDTH`=1, `d0`=0, `d1`=1, `d2`=0, `sel`=00 → `y`=0; after one `clk` edge, `y_q`=0.
- Same data, `sel`=10 → `y`=0 immediately. Then `d2` driven to 1 with `sel` held → `y`=1 with no clock edge.
- `d0`=`d1`=`d2`=1, `sel`=01 → `y`=1; `y_q`=1 one cycle later. Then `d1`=0 → `y`=0 immediately, with `y_q` still 1 until the next edge.
- `sel`=11 with all data=1 → `y`=0. With `MUX_3X1_SEL_ERR_EN`, `sel_err`=1 after the next edge, and it stays 1 after `sel` returns to 00.
- `WIDTH`=8, `d0`=8'hA5, `d1`=8'h3C, `d2`=8'hF0, `sel` stepped 00, 01, 10 → `y`=A5, 3C, F0; `y_q` follows one cycle behind.
- With `y_q`=8'hF0 and `sel_err`=1, assert `rst_n`=0 between clock edges → both outputs read 0 immediately. `y` continues to track its inputs throughout.

Source files
------------

// File: rtl/mux_3x1_if.sv
// Bundle of the three data sources, the select code and the mux outputs.
// The sel_err member only exists when MUX_3X1_SEL_ERR_EN is defined.
interface mux_3x1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
`ifdef MUX_3X1_SEL_ERR_EN
    logic             sel_err;
`endif

    // The source side drives data and select; the mux side returns both outputs.
    modport master (
        output d0,
        output d1,
        output d2,
        output sel,
        input  y,
`ifdef MUX_3X1_SEL_ERR_EN
        input  sel_err,
`endif
        input  y_q
    );

    modport slave (
        input  d0,
        input  d1,
        input  d2,
        input  sel,
        output y,
`ifdef MUX_3X1_SEL_ERR_EN
        output sel_err,
`endif
        output y_q
    );
endinterface

// File: rtl/mux_3x1.sv
// 3-to-1 selector with a combinational output, a registered copy and, when
// MUX_3X1_SEL_ERR_EN is defined, a sticky flag for the illegal select code 2'b11.
module mux_3x1 #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_3x1_if.slave    bus
);
    logic [WIDTH-1:0] sel_data;

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("mux_3x1: WIDTH must be in 1..64");
    end

    // Code 2'b11 resolves to zero so it never aliases one of the sources.
    always_comb begin
        sel_data = '0;
        unique case (bus.sel)
            2'b00:   sel_data = bus.d0;
            2'b01:   sel_data = bus.d1;
            2'b10:   sel_data = bus.d2;
            default: sel_data = '0;
        endcase
    end

    assign bus.y = sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y_q <= '0;
        end else begin
            bus.y_q <= sel_data;
        end
    end

`ifdef MUX_3X1_SEL_ERR_EN
    // Sticky: once an illegal select is seen, only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sel_err <= 1'b0;
        end else if (bus.sel == 2'b11) begin
            bus.sel_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mux_3x1.sv
// Directed bench for mux_3x1: a 1-bit and an 8-bit instance driven in lockstep,
// the 1-bit one sees bit 0 of each 8-bit source.
module tb_mux_3x1;
    logic clk;
    logic rst_n;
    int   check_count;
    int   pass_count;

    mux_3x1_if #(.WIDTH(1)) bus_a ();
    mux_3x1_if #(.WIDTH(8)) bus_b ();

    mux_3x1 #(.WIDTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_3x1 #(.WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] c);
        bus_a.sel = s;
        bus_a.d0  = a[0];
        bus_a.d1  = b[0];
        bus_a.d2  = c[0];
        bus_b.sel = s;
        bus_b.d0  = a;
        bus_b.d1  = b;
        bus_b.d2  = c;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n = 1'b0;
        applyStimulus(2'b00, 8'h00, 8'h01, 8'h00);
        #1;
        checkOutput("reset_yq_a", bus_a.y_q, 0);
        checkOutput("reset_yq_b", bus_b.y_q, 0);
        checkOutput("reset_y_a", bus_a.y, 0);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("reset_err_a", bus_a.sel_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("sel0_y_a", bus_a.y, 0);
        stepEdge();
        checkOutput("sel0_yq_a", bus_a.y_q, 0);

        applyStimulus(2'b10, 8'h00, 8'h01, 8'h00);
        #1;
        checkOutput("sel2_y_a", bus_a.y, 0);
        applyStimulus(2'b10, 8'h00, 8'h01, 8'h01);
        #1;
        checkOutput("sel2_d2chg_y_a", bus_a.y, 1);
        checkOutput("sel2_d2chg_y_b", bus_b.y, 8'h01);

        applyStimulus(2'b01, 8'hFF, 8'hFF, 8'hFF);
        #1;
        checkOutput("sel1_y_a", bus_a.y, 1);
        stepEdge();
        checkOutput("sel1_yq_a", bus_a.y_q, 1);
        checkOutput("sel1_yq_b", bus_b.y_q, 8'hFF);
        applyStimulus(2'b01, 8'hFF, 8'h00, 8'hFF);
        #1;
        checkOutput("sel1_d1chg_y_a", bus_a.y, 0);
        checkOutput("sel1_hold_yq_a", bus_a.y_q, 1);
        checkOutput("sel1_d1chg_y_b", bus_b.y, 8'h00);
        stepEdge();
        checkOutput("sel1_next_yq_a", bus_a.y_q, 0);

        applyStimulus(2'b11, 8'hFF, 8'hFF, 8'hFF);
        #1;
        checkOutput("sel3_y_a", bus_a.y, 0);
        checkOutput("sel3_y_b", bus_b.y, 8'h00);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("sel3_err_pre_a", bus_a.sel_err, 0);
`endif
        stepEdge();
        checkOutput("sel3_yq_b", bus_b.y_q, 8'h00);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("sel3_err_a", bus_a.sel_err, 1);
        checkOutput("sel3_err_b", bus_b.sel_err, 1);
`endif
        applyStimulus(2'b00, 8'hFF, 8'hFF, 8'hFF);
        #1;
        checkOutput("sel0_after3_y_a", bus_a.y, 1);
        stepEdge();
        checkOutput("sel0_after3_yq_b", bus_b.y_q, 8'hFF);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("err_sticky_a", bus_a.sel_err, 1);
        checkOutput("err_sticky_b", bus_b.sel_err, 1);
`endif

        applyStimulus(2'b00, 8'hA5, 8'h3C, 8'hF0);
        #1;
        checkOutput("w8_sel0_y", bus_b.y, 8'hA5);
        checkOutput("w8_sel0_y_a", bus_a.y, 1);
        stepEdge();
        checkOutput("w8_sel0_yq", bus_b.y_q, 8'hA5);
        applyStimulus(2'b01, 8'hA5, 8'h3C, 8'hF0);
        #1;
        checkOutput("w8_sel1_y", bus_b.y, 8'h3C);
        checkOutput("w8_sel1_yq_lag", bus_b.y_q, 8'hA5);
        stepEdge();
        checkOutput("w8_sel1_yq", bus_b.y_q, 8'h3C);
        applyStimulus(2'b10, 8'hA5, 8'h3C, 8'hF0);
        #1;
        checkOutput("w8_sel2_y", bus_b.y, 8'hF0);
        stepEdge();
        checkOutput("w8_sel2_yq", bus_b.y_q, 8'hF0);
        checkOutput("w8_sel2_yq_a", bus_a.y_q, 0);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_yq_b", bus_b.y_q, 8'h00);
        checkOutput("midrst_yq_a", bus_a.y_q, 0);
        checkOutput("midrst_y_b", bus_b.y, 8'hF0);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("midrst_err_a", bus_a.sel_err, 0);
        checkOutput("midrst_err_b", bus_b.sel_err, 0);
`endif
        applyStimulus(2'b10, 8'hA5, 8'h3C, 8'h0F);
        #1;
        checkOutput("rst_track_y_b", bus_b.y, 8'h0F);
        checkOutput("rst_track_y_a", bus_a.y, 1);
        stepEdge();
        checkOutput("rst_hold_yq_b", bus_b.y_q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        stepEdge();
        checkOutput("release_yq_b", bus_b.y_q, 8'h0F);
        checkOutput("release_yq_a", bus_a.y_q, 1);
`ifdef MUX_3X1_SEL_ERR_EN
        checkOutput("release_err_b", bus_b.sel_err, 0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
